decode_stage: RTL and testbench

//  Registered RV32I decode stage with valid/ready handshake on both sides.

---
 rtl/decode_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder between fetch and execute, 2-entry skid buffer; `define RV32M_EN adds M decode.
// Latency: 1 cycle from accept to out_*; flush or reset empties both entries at the next edge.
// Backpressure: in_ready = !skid_vld_q (registered only); a stalled main entry holds out_* stable.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [4:0]      operation,
   output logic            alu_src,
   output logic [XLEN-1:0] imm,
   output logic            jump,
   output logic            branch,
   output logic            store,
   output logic            write,
   output logic [1:0]      rd_src,
   output logic [2:0]      mem_size,
   output logic            illegal
);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [4:0]      operation;
      logic            alu_src;
      logic [XLEN-1:0] imm;
      logic            jump;
      logic            branch;
      logic            store;
      logic            write;
      logic [1:0]      rd_src;
      logic [2:0]      mem_size;
      logic            illegal;
   } bundle_t;

   localparam bundle_t BUNDLE_RST = '{mem_size: 3'b010, default: '0};

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            legal, wr_en;
   bundle_t         dec;

   assign opc   = in_instr[6:0];
   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = XLEN'($signed(in_instr[31:20]));
   assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

   always_comb begin
      legal  = 1'b1;
      wr_en  = 1'b0;
      dec    = BUNDLE_RST;
      dec.pc = in_pc;
      case (opc)
         OPC_R: begin
            dec.rs1 = in_instr[19:15];
            dec.rs2 = in_instr[24:20];
            dec.rd  = in_instr[11:7];
            wr_en   = 1'b1;
            if (f7 == 7'b0000000 || f7 == 7'b0100000) dec.operation = {1'b0, in_instr[30], f3};
`ifdef RV32M_EN
            else if (f7 == 7'b0000001) dec.operation = {2'b11, f3};
`endif
            else legal = 1'b0;
         end
         OPC_I: begin
            dec.rs1       = in_instr[19:15];
            dec.rd        = in_instr[11:7];
            dec.alu_src   = 1'b1;
            dec.imm       = imm_i;
            // only the right shifts carry the arithmetic/logical select in bit 30
            dec.operation = (f3 == 3'b101) ? {1'b0, in_instr[30], f3} : {2'b00, f3};
            wr_en         = 1'b1;
         end
         OPC_LOAD: begin
            dec.rs1      = in_instr[19:15];
            dec.rd       = in_instr[11:7];
            dec.alu_src  = 1'b1;
            dec.imm      = imm_i;
            dec.rd_src   = 2'd1;
            dec.mem_size = f3;
            wr_en        = 1'b1;
         end
         OPC_STORE: begin
            dec.rs1      = in_instr[19:15];
            dec.rs2      = in_instr[24:20];
            dec.alu_src  = 1'b1;
            dec.imm      = imm_s;
            dec.store    = 1'b1;
            dec.mem_size = f3;
         end
         OPC_BRANCH: begin
            dec.rs1       = in_instr[19:15];
            dec.rs2       = in_instr[24:20];
            dec.imm       = imm_b;
            dec.branch    = 1'b1;
            dec.operation = {2'b10, f3};
         end
         OPC_JAL: begin
            dec.rd     = in_instr[11:7];
            dec.imm    = imm_j;
            dec.jump   = 1'b1;
            dec.rd_src = 2'd3;
            wr_en      = 1'b1;
         end
         OPC_JALR: begin
            dec.rs1     = in_instr[19:15];
            dec.rd      = in_instr[11:7];
            dec.imm     = imm_i;
            dec.jump    = 1'b1;
            dec.alu_src = 1'b1;
            dec.rd_src  = 2'd3;
            wr_en       = 1'b1;
         end
         OPC_LUI: begin
            dec.rd      = in_instr[11:7];
            dec.imm     = imm_u;
            dec.alu_src = 1'b1;
            wr_en       = 1'b1;
         end
         OPC_AUIPC: begin
            dec.rd      = in_instr[11:7];
            dec.imm     = imm_u;
            dec.alu_src = 1'b1;
            dec.rd_src  = 2'd2;
            wr_en       = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal || in_instr[1:0] != 2'b11) begin
         dec         = BUNDLE_RST;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end else begin
         dec.write = wr_en && (dec.rd != 5'd0);
      end
   end

   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic    accept, pop;

   assign in_ready = !skid_vld_q;
   assign accept   = in_valid && !skid_vld_q && !flush;
   assign pop      = main_vld_q && out_ready;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || pop) begin
         // accept is impossible while skid holds data, so the refill never competes with it
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = accept;
            if (accept) main_d = dec;
         end
      end else if (accept) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q     <= BUNDLE_RST;
         skid_q     <= BUNDLE_RST;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid = main_vld_q;
   assign out_pc    = main_q.pc;
   assign rs1       = main_q.rs1;
   assign rs2       = main_q.rs2;
   assign rd        = main_q.rd;
   assign operation = main_q.operation;
   assign alu_src   = main_q.alu_src;
   assign imm       = main_q.imm;
   assign jump      = main_q.jump;
   assign branch    = main_q.branch;
   assign store     = main_q.store;
   assign write     = main_q.write;
   assign rd_src    = main_q.rd_src;
   assign mem_size  = main_q.mem_size;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic against a queue-based reference.
module tb_decode_stage;
   localparam int XLEN = 32;
   localparam int PC_W = 32;
`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr;
   logic [PC_W-1:0] in_pc, out_pc;
   logic [4:0] rs1, rs2, rd, operation;
   logic alu_src, jump, branch, store, write, illegal;
   logic [XLEN-1:0] imm;
   logic [1:0] rd_src;
   logic [2:0] mem_size;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .operation(operation), .alu_src(alu_src), .imm(imm),
      .jump(jump), .branch(branch), .store(store), .write(write), .rd_src(rd_src),
      .mem_size(mem_size), .illegal(illegal)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd, op;
      logic        alu_src;
      logic [31:0] imm;
      logic        jump, branch, store, write;
      logic [1:0]  rd_src;
      logic [2:0]  mem_size;
      logic        illegal;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;

   txn_t q[$];
   exp_t rst_exp;
   logic [6:0] opcodes [0:8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t dut_b();
      return {out_pc, rs1, rs2, rd, operation, alu_src, imm, jump, branch, store, write,
              rd_src, mem_size, illegal};
   endfunction

   // Reference decode built from the instruction-set rules with integer arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      int s, f3, f7, opc;
      bit ok, wr;
      s = int'(ins);
      opc = s & 127;
      f3 = (s >>> 12) & 7;
      f7 = (s >>> 25) & 127;
      e = '0;
      e.pc = pc;
      e.mem_size = 3'd2;
      ok = 1;
      wr = 0;
      case (opc)
         'h33: begin
            ok = (f7 == 0) || (f7 == 32) || (M_EN && f7 == 1);
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; wr = 1;
            e.op = 5'((f7 == 1) ? 24 + f3 : ((f7 == 32) ? 8 : 0) + f3);
         end
         'h13: begin
            e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.alu_src = 1; wr = 1;
            e.imm = 32'(s >>> 20);
            e.op = 5'((f3 == 5 && ins[30]) ? 13 : f3);
         end
         'h03: begin
            e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.alu_src = 1; e.rd_src = 1; wr = 1;
            e.imm = 32'(s >>> 20); e.mem_size = 3'(f3);
         end
         'h23: begin
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.alu_src = 1; e.store = 1;
            e.imm = 32'(((s >>> 25) <<< 5) | ((s >>> 7) & 31)); e.mem_size = 3'(f3);
         end
         'h63: begin
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.branch = 1; e.op = 5'(16 + f3);
            e.imm = 32'(((s >>> 31) <<< 12) | (((s >>> 7) & 1) <<< 11) |
                        (((s >>> 25) & 63) <<< 5) | (((s >>> 8) & 15) <<< 1));
         end
         'h6F: begin
            e.rd = ins[11:7]; e.jump = 1; e.rd_src = 3; wr = 1;
            e.imm = 32'(((s >>> 31) <<< 20) | (((s >>> 12) & 255) <<< 12) |
                        (((s >>> 20) & 1) <<< 11) | (((s >>> 21) & 1023) <<< 1));
         end
         'h67: begin
            e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.jump = 1; e.alu_src = 1; e.rd_src = 3; wr = 1;
            e.imm = 32'(s >>> 20);
         end
         'h37: begin
            e.rd = ins[11:7]; e.alu_src = 1; wr = 1; e.imm = 32'(s & 32'hFFFFF000);
         end
         'h17: begin
            e.rd = ins[11:7]; e.alu_src = 1; e.rd_src = 2; wr = 1; e.imm = 32'(s & 32'hFFFFF000);
         end
         default: ok = 0;
      endcase
      if (!ok) begin
         e = '0;
         e.pc = pc;
         e.mem_size = 3'd2;
         e.illegal = 1;
      end else begin
         e.write = wr && (e.rd != 0);
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int k;
      r = $urandom();
      k = $urandom_range(0, 9);
      if (k < 9) r[6:0] = opcodes[k];
      if (r[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
         endcase
      end
      if ($urandom_range(0, 19) == 0) r[1:0] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc = pc;
   endtask

   // Compare against the model mid-cycle, then advance one edge and update the model.
   task automatic cyc();
      bit rdy_m, pop, push;
      rdy_m = (q.size() < 2);
      chk("in_ready", in_ready, rdy_m);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("bundle", dut_b(), ref_decode(q[0].instr, q[0].pc));
      pop = (q.size() > 0) && out_ready;
      push = in_valid && rdy_m && !flush;
      @(posedge clk);
      #1;
      if (reset || flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back('{instr: in_instr, pc: in_pc});
      end
   endtask

   initial begin
      rst_exp = '0;
      rst_exp.mem_size = 3'b010;
      reset = 1; flush = 0; out_ready = 0;
      drive(0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_bundle", dut_b(), rst_exp);
      reset = 0;

      // addi x1,x0,-1
      out_ready = 1;
      drive(1, 32'hFFF00093, 32'h1000);
      cyc();
      chk("t1_out_valid", out_valid, 1'b1);
      chk("t1_rd", rd, 5'd1);
      chk("t1_rs1", rs1, 5'd0);
      chk("t1_imm", imm, 32'hFFFFFFFF);
      chk("t1_alu_src", alu_src, 1'b1);
      chk("t1_write", write, 1'b1);
      chk("t1_operation", operation, 5'd0);

      // beq x1,x2,-4
      drive(1, 32'hFE208EE3, 32'h1004);
      cyc();
      chk("t2_branch", branch, 1'b1);
      chk("t2_operation", operation, 5'b10000);
      chk("t2_rs1", rs1, 5'd1);
      chk("t2_rs2", rs2, 5'd2);
      chk("t2_imm", imm, 32'hFFFFFFFC);
      chk("t2_write", write, 1'b0);
      drive(0, 32'h0, 32'h0);
      cyc();

      // three back-to-back offers into a stalled stage
      out_ready = 0;
      drive(1, 32'h002082B3, 32'h100); cyc();
      drive(1, 32'h40208333, 32'h104); cyc();
      drive(1, 32'h0080A383, 32'h108);
      chk("t3_in_ready_full", in_ready, 1'b0);
      cyc();
      out_ready = 1;
      chk("t3_first_pc", out_pc, 32'h100);
      cyc();
      chk("t3_second_pc", out_pc, 32'h104);
      cyc();
      chk("t3_third_pc", out_pc, 32'h108);
      drive(0, 32'h0, 32'h0);
      cyc();
      chk("t3_drained", out_valid, 1'b0);

      // flush with both entries full and a same-cycle offer
      out_ready = 0;
      drive(1, 32'h002082B3, 32'h200); cyc();
      drive(1, 32'h40208333, 32'h204); cyc();
      flush = 1;
      drive(1, 32'h00100093, 32'h208);
      cyc();
      flush = 0;
      drive(0, 32'h0, 32'h0);
      chk("t4_out_valid", out_valid, 1'b0);
      chk("t4_in_ready", in_ready, 1'b1);
      out_ready = 1;
      repeat (3) cyc();
      chk("t4_no_ghost", out_valid, 1'b0);

      // mul x3,x1,x2
      drive(1, 32'h022081B3, 32'h300);
      cyc();
      drive(0, 32'h0, 32'h0);
      chk("t5_operation", operation, M_EN ? 5'b11000 : 5'b00000);
      chk("t5_write", write, M_EN);
      chk("t5_illegal", illegal, !M_EN);
      cyc();

      // addi x0,x0,5 then reset with both entries full
      drive(1, 32'h00500013, 32'h400);
      cyc();
      chk("t6_write_x0", write, 1'b0);
      chk("t6_imm", imm, 32'd5);
      out_ready = 0;
      drive(1, 32'h002082B3, 32'h404); cyc();
      drive(1, 32'h40208333, 32'h408); cyc();
      reset = 1;
      drive(1, 32'h00100093, 32'h40C);
      cyc();
      reset = 0;
      drive(0, 32'h0, 32'h0);
      chk("t6_rst_out_valid", out_valid, 1'b0);
      chk("t6_rst_in_ready", in_ready, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom());
         out_ready = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 39) == 0;
         reset = $urandom_range(0, 199) == 0;
         cyc();
      end
      reset = 0;
      flush = 0;
      drive(0, 32'h0, 32'h0);
      out_ready = 1;
      repeat (3) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
